// File: rtl/alu_ctrl_pkg.sv
// +-----------------------------------------------------------------------+
// | Package : alu_ctrl_pkg                                                |
// | Purpose : Shared constants, state encoding and helpers for the        |
// |           multi-cycle ALU control / multiply-divide block.            |
// | Config  : ALU_CTRL_DIV_EN - when defined, div/divu count as MD ops.   |
// | Rev     : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

package alu_ctrl_pkg;

  // ALU operation select codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  // R-type funct field values
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } md_state_e;

  // True for every funct handled by the multiply/divide unit in this build.
  function automatic logic is_md_funct(input logic [5:0] f);
    case (f)
      F_MULT, F_MULTU, F_MFHI, F_MTHI, F_MFLO, F_MTLO: return 1'b1;
`ifdef ALU_CTRL_DIV_EN
      F_DIV, F_DIVU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_control_mc_md_iter.sv
// +-----------------------------------------------------------------------+
// | Module  : md_iter                                                     |
// | Purpose : Radix-2 iterative datapath: shift-add multiply and          |
// |           restoring shift-subtract divide on unsigned magnitudes.     |
// | Ports   : clk, rst_n       - clock, async active-low reset            |
// |           start, mode      - load operands; mode=1 selects divide     |
// |           step             - perform one iteration this cycle         |
// |           a, b             - multiplier/dividend, multiplicand/divisor|
// |           raw_hi, raw_lo   - product halves or remainder/quotient     |
// |           last             - high on the final step                   |
// | Config  : ALU_CTRL_DIV_EN - builds the divide subtractor.             |
// | Rev     : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module md_iter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic              mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] raw_hi,
  output logic [DATA_W-1:0] raw_lo,
  output logic              last
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [CNT_W-1:0]  count;
  logic              div_mode;
  logic [DATA_W-1:0] acc;       // running high half / partial remainder
  logic [DATA_W-1:0] shreg;     // multiplier bits out, quotient bits in
  logic [DATA_W-1:0] opb_q;
  logic [DATA_W-1:0] acc_nx;
  logic [DATA_W-1:0] shreg_nx;
  logic [DATA_W:0]   mul_sum;

  // Carry out of the add becomes the new top bit of acc after the right shift.
  assign mul_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});

`ifdef ALU_CTRL_DIV_EN
  logic [DATA_W:0] partial;
  logic [DATA_W:0] trial;

  assign partial = {acc, shreg[DATA_W-1]};
  assign trial   = partial - {1'b0, opb_q};

  always_comb begin
    acc_nx   = mul_sum[DATA_W:1];
    shreg_nx = {mul_sum[0], shreg[DATA_W-1:1]};
    if (div_mode) begin
      // Borrow (trial MSB) means the divisor did not fit: restore.
      if (!trial[DATA_W]) begin
        acc_nx   = trial[DATA_W-1:0];
        shreg_nx = {shreg[DATA_W-2:0], 1'b1};
      end else begin
        acc_nx   = partial[DATA_W-1:0];
        shreg_nx = {shreg[DATA_W-2:0], 1'b0};
      end
    end
  end
`else
  logic unused_div_mode;
  assign unused_div_mode = div_mode;

  always_comb begin
    acc_nx   = mul_sum[DATA_W:1];
    shreg_nx = {mul_sum[0], shreg[DATA_W-1:1]};
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      div_mode <= 1'b0;
      acc      <= '0;
      shreg    <= '0;
      opb_q    <= '0;
    end else if (start) begin
      count    <= '0;
      div_mode <= mode;
      acc      <= '0;
      shreg    <= a;
      opb_q    <= b;
    end else if (step) begin
      acc   <= acc_nx;
      shreg <= shreg_nx;
      count <= last ? '0 : count + CNT_W'(1);
    end
  end

  assign last   = step && (count == CNT_W'(DATA_W-1));
  assign raw_hi = acc;
  assign raw_lo = shreg;

endmodule

`default_nettype wire

// File: rtl/alu_control_mc.sv
// +-----------------------------------------------------------------------+
// | Module  : alu_control_mc                                              |
// | Purpose : ALU control decode plus iterative multiply/divide unit with |
// |           HI/LO registers and front-end stall interlock.              |
// | Ports   : clk, rst_n          - clock, async active-low reset         |
// |           valid_in, aluop,    - ALU-stage instruction                 |
// |           funct, opa, opb                                             |
// |           alucontrol, illegal - combinational decode                  |
// |           stall               - hold the front end                    |
// |           md_busy, md_done    - engine status / completion pulse      |
// |           md_rdata            - HI or LO for mfhi/mflo                |
// | Config  : ALU_CTRL_DIV_EN - enables div/divu.                         |
// | Rev     : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none

module alu_control_mc
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [1:0]        aluop,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [3:0]        alucontrol,
  output logic              illegal,
  output logic              stall,
  output logic              md_busy,
  output logic              md_done,
  output logic [DATA_W-1:0] md_rdata
);

  md_state_e state, state_nx;

  logic [DATA_W-1:0]   hi, lo;
  logic                res_neg, rem_neg, div_zero, op_div, done;
  logic                md_op, accept, start_mul, start_div, is_signed;
  logic [DATA_W-1:0]   opa_mag, opb_mag, raw_hi, raw_lo;
  logic [DATA_W-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;
  logic [2*DATA_W-1:0] prod, prod_fix;
  logic                iter_last;

  // ---------------- decode ----------------
  always_comb begin
    alucontrol = ALU_BAD;
    illegal    = 1'b0;
    case (aluop)
      2'b00: alucontrol = ALU_ADD;
      2'b01: alucontrol = ALU_SUB;
      2'b11: alucontrol = ALU_AND;
      default: begin
        case (funct)
          F_ADD: alucontrol = ALU_ADD;
          F_SUB: alucontrol = ALU_SUB;
          F_AND: alucontrol = ALU_AND;
          F_OR:  alucontrol = ALU_OR;
          F_NOR: alucontrol = ALU_NOR;
          F_SLT: alucontrol = ALU_SLT;
          default: begin
            if (is_md_funct(funct)) begin
              alucontrol = ALU_ADD;
            end else begin
              illegal = 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  // ---------------- issue / interlock ----------------
  assign md_op     = valid_in && (aluop == 2'b10) && is_md_funct(funct);
  assign accept    = md_op && (state == IDLE);
  assign stall     = md_op && (state != IDLE);
  assign start_mul = accept && ((funct == F_MULT) || (funct == F_MULTU));
`ifdef ALU_CTRL_DIV_EN
  assign start_div = accept && ((funct == F_DIV) || (funct == F_DIVU));
`else
  assign start_div = 1'b0;
`endif

  // Signed forms have funct[0]=0 (mult, div); unsigned forms pass raw values.
  assign is_signed = ~funct[0];
  assign opa_mag   = (is_signed && opa[DATA_W-1]) ? -opa : opa;
  assign opb_mag   = (is_signed && opb[DATA_W-1]) ? -opb : opb;

  md_iter #(.DATA_W(DATA_W)) u_md_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start_mul || start_div),
    .step   ((state == MUL) || (state == DIV)),
    .mode   (start_div),
    .a      (opa_mag),
    .b      (opb_mag),
    .raw_hi (raw_hi),
    .raw_lo (raw_lo),
    .last   (iter_last)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start_mul) begin
          state_nx = MUL;
        end else if (start_div) begin
          state_nx = DIV;
        end
      end
      MUL, DIV: begin
        if (iter_last) begin
          state_nx = FIX;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- sign correction ----------------
  // min / -1 falls out naturally: |min| = min, quotient 2^(W-1) negates to min.
  assign prod     = {raw_hi, raw_lo};
  assign prod_fix = res_neg ? -prod : prod;
  assign quo_fix  = div_zero ? {DATA_W{1'b1}} : (res_neg ? -raw_lo : raw_lo);
  assign rem_fix  = rem_neg ? -raw_hi : raw_hi;
  assign hi_fix   = op_div ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
  assign lo_fix   = op_div ? quo_fix : prod_fix[DATA_W-1:0];

  // ---------------- HI/LO and status ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi       <= '0;
      lo       <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      op_div   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_mul || start_div) begin
        res_neg  <= is_signed && (opa[DATA_W-1] ^ opb[DATA_W-1]);
        rem_neg  <= is_signed && opa[DATA_W-1];
        div_zero <= (opb == '0);
        op_div   <= start_div;
      end
      if (accept && (funct == F_MTHI)) begin
        hi <= opa;
      end
      if (accept && (funct == F_MTLO)) begin
        lo <= opa;
      end
      if (state == FIX) begin
        hi   <= hi_fix;
        lo   <= lo_fix;
        done <= 1'b1;
      end
    end
  end

  assign md_busy  = (state != IDLE);
  assign md_done  = done;
  assign md_rdata = (funct == F_MFHI) ? hi : lo;

endmodule

`default_nettype wire

// File: tb/tb_alu_control_mc.sv
// +-----------------------------------------------------------------------+
// | Module  : tb_alu_control_mc                                           |
// | Purpose : Directed self-checking bench for alu_control_mc.            |
// | Config  : ALU_CTRL_DIV_EN - selects divide vectors vs. illegal checks.|
// | Rev     : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_alu_control_mc;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              valid_in;
  logic [1:0]        aluop;
  logic [5:0]        funct;
  logic [DATA_W-1:0] opa, opb;
  logic [3:0]        alucontrol;
  logic              illegal, stall, md_busy, md_done;
  logic [DATA_W-1:0] md_rdata;

  int checks = 0;
  int errors = 0;

  alu_control_mc #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .aluop      (aluop),
    .funct      (funct),
    .opa        (opa),
    .opb        (opb),
    .alucontrol (alucontrol),
    .illegal    (illegal),
    .stall      (stall),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_rdata   (md_rdata)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {illegal, alucontrol} from the decode table
  function automatic logic [4:0] exp_dec(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b00: return 5'b0_0010;
      2'b01: return 5'b0_0110;
      2'b11: return 5'b0_0000;
      default: begin
        case (f)
          6'b100000: return 5'b0_0010;
          6'b100010: return 5'b0_0110;
          6'b100100: return 5'b0_0000;
          6'b100101: return 5'b0_0001;
          6'b100111: return 5'b0_1100;
          6'b101010: return 5'b0_0111;
          6'b011000, 6'b011001, 6'b010000,
          6'b010001, 6'b010010, 6'b010011: return 5'b0_0010;
`ifdef ALU_CTRL_DIV_EN
          6'b011010, 6'b011011: return 5'b0_0010;
`endif
          default: return 5'b1_1111;
        endcase
      end
    endcase
  endfunction

  // Counts cycles (after the issue edge) until md_done; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      if (md_done) begin
        lat = n;
        break;
      end
      tick();
    end
  endtask

  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat);
    valid_in = 1'b1;
    aluop    = 2'b10;
    funct    = f;
    opa      = a;
    opb      = b;
    tick();
    valid_in = 1'b0;
    funct    = 6'b100000;
    check_value("busy_after_issue", {63'd0, md_busy}, 64'd1);
    wait_done(lat);
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] eh, input logic [31:0] el);
    valid_in = 1'b0;
    aluop    = 2'b10;
    funct    = 6'b010000;
    #1;
    check_value({tag, "_hi"}, {32'd0, md_rdata}, {32'd0, eh});
    funct = 6'b010010;
    #1;
    check_value({tag, "_lo"}, {32'd0, md_rdata}, {32'd0, el});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: timeout expired");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int cnt;

    rst_n = 1'b0; valid_in = 1'b0; aluop = 2'b00; funct = 6'd0; opa = '0; opb = '0;
    #3;
    // combinational outputs follow inputs during reset
    aluop = 2'b01;
    #1;
    check_value("rst_decode", {60'd0, alucontrol}, 64'h6);
    aluop = 2'b10; funct = 6'b011000; valid_in = 1'b1; opa = 32'd3; opb = 32'd3;
    #1;
    check_value("rst_stall", {63'd0, stall}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check_value("rst_busy", {63'd0, md_busy}, 64'd0);
    check_value("rst_done", {63'd0, md_done}, 64'd0);
    read_hilo("rst", 32'h0, 32'h0);
    rst_n = 1'b1;
    tick();

    // decode sweep (valid low, no MD side effects)
    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 64; f++) begin
        aluop = op[1:0];
        funct = f[5:0];
        #1;
        check_value($sformatf("decode_op%0d_f%0h", op, f), {59'd0, illegal, alucontrol},
                    {59'd0, exp_dec(op[1:0], f[5:0])});
      end
    end
    tick();

    // mult -3 x 7
    run_md(6'b011000, 32'hFFFF_FFFD, 32'd7, lat);
    check_value("mult_latency", lat, 64'd34);
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    // multu issued in the md_done cycle (back-to-back)
    run_md(6'b011001, 32'hFFFF_FFFF, 32'd2, lat);
    check_value("multu_latency", lat, 64'd34);
    read_hilo("multu", 32'h1, 32'hFFFF_FFFE);
    tick();
    check_value("done_pulse_end", {63'd0, md_done}, 64'd0);

`ifdef ALU_CTRL_DIV_EN
    run_md(6'b011011, 32'd100, 32'd7, lat);
    check_value("divu_latency", lat, 64'd34);
    read_hilo("divu", 32'd2, 32'd14);
    run_md(6'b011010, 32'hFFFF_FFF9, 32'd2, lat);
    read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md(6'b011010, 32'd5, 32'd0, lat);
    check_value("div0_latency", lat, 64'd34);
    read_hilo("div0", 32'd5, 32'hFFFF_FFFF);
    run_md(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    read_hilo("div_ovf", 32'd0, 32'h8000_0000);
`else
    valid_in = 1'b1; aluop = 2'b10; funct = 6'b011010; opa = 32'd5; opb = 32'd1;
    #1;
    check_value("div_disabled_illegal", {59'd0, illegal, alucontrol}, 64'h1F);
    tick();
    check_value("div_disabled_busy", {63'd0, md_busy}, 64'd0);
    valid_in = 1'b0;
`endif

    // mthi / mtlo
    valid_in = 1'b1; aluop = 2'b10; funct = 6'b010001; opa = 32'h1234_5678;
    tick();
    funct = 6'b010011; opa = 32'h9ABC_DEF0;
    tick();
    read_hilo("mtx", 32'h1234_5678, 32'h9ABC_DEF0);

    // interlock: mflo right behind mult
    valid_in = 1'b1; aluop = 2'b10; funct = 6'b011000; opa = 32'd6; opb = 32'd7;
    tick();
    funct = 6'b010010;
    #1;
    cnt = 0;
    for (int n = 0; n < 100; n++) begin
      if (!stall) break;
      cnt++;
      tick();
    end
    check_value("stall_cycles", cnt, 64'd33);
    check_value("mflo_after_stall", {32'd0, md_rdata}, 64'd42);
    check_value("done_with_mflo", {63'd0, md_done}, 64'd1);
    valid_in = 1'b0;

    // non-MD instruction proceeds while busy
    valid_in = 1'b1; aluop = 2'b10; funct = 6'b011000; opa = 32'd3; opb = 32'd5;
    tick();
    funct = 6'b100000;
    #1;
    check_value("add_no_stall", {63'd0, stall}, 64'd0);
    check_value("add_decode", {59'd0, illegal, alucontrol}, 64'h02);
    tick();
    funct = 6'b010000;
    #1;
    check_value("mfhi_stalls", {63'd0, stall}, 64'd1);
    valid_in = 1'b0;
    wait_done(lat);
    check_value("mult2_done_seen", {63'd0, lat > 0}, 64'd1);
    read_hilo("mult2", 32'd0, 32'd15);

    // asynchronous reset at step 10
    valid_in = 1'b1; aluop = 2'b10; opa = 32'd100; opb = 32'd7;
`ifdef ALU_CTRL_DIV_EN
    funct = 6'b011011;
`else
    funct = 6'b011000;
`endif
    tick();
    valid_in = 1'b0;
    repeat (10) tick();
    check_value("busy_before_abort", {63'd0, md_busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check_value("abort_busy", {63'd0, md_busy}, 64'd0);
    check_value("abort_done", {63'd0, md_done}, 64'd0);
    read_hilo("abort", 32'd0, 32'd0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (md_done) cnt++;
      tick();
    end
    check_value("no_done_after_abort", cnt, 64'd0);
    run_md(6'b011000, 32'd6, 32'hFFFF_FFF9, lat);
    check_value("post_reset_latency", lat, 64'd34);
    read_hilo("post_reset", 32'hFFFF_FFFF, 32'hFFFF_FFD6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
